// File: rtl/ahb_arbiter.sv
// Two-manager AHB-Lite arbiter: round-robin address grant with SEQ burst lock,
// data-phase hwdata routing and per-manager read-data hold for stalled managers.
module ahb_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hresp
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e            r_owner;
  logic              r_last_grant;
  logic [1:0]        r_hold_valid;
  logic [DATA_W-1:0] r_hold_rdata0;
  logic [DATA_W-1:0] r_hold_rdata1;
  logic              r_hold_resp0;
  logic              r_hold_resp1;

  logic w_req0, w_req1, w_lock, w_gnt_vld, w_gnt;
  logic w_stall0, w_stall1, w_rdy0, w_rdy1, w_cap0, w_cap1;

  // Grant: burst lock first, then single requester, then alternate on a tie.
  always_comb begin
    w_req0    = m0_htrans[1];
    w_req1    = m1_htrans[1];
    w_lock    = r_last_grant ? (m1_htrans == HTRANS_SEQ) : (m0_htrans == HTRANS_SEQ);
    w_gnt_vld = w_req0 | w_req1;
    w_gnt     = ~r_last_grant;
    if (w_lock)               w_gnt = r_last_grant;
    else if (w_req0 && !w_req1) w_gnt = 1'b0;
    else if (w_req1 && !w_req0) w_gnt = 1'b1;
    w_stall0  = w_req0 && w_gnt;
    w_stall1  = w_req1 && !w_gnt;
    w_rdy0    = !w_stall0 && s_hready;
    w_rdy1    = !w_stall1 && s_hready;
    w_cap0    = w_stall0 && s_hready && (r_owner == OWN_M0);
    w_cap1    = w_stall1 && s_hready && (r_owner == OWN_M1);
  end

  // Subordinate-side address/control and write-data muxes.
  always_comb begin
    s_haddr  = '0;
    s_htrans = HTRANS_IDLE;
    s_hwrite = 1'b0;
    s_hsize  = 3'b000;
    s_hburst = 3'b000;
    s_hwdata = '0;
    if (nrst && w_gnt_vld) begin
      if (w_gnt) begin
        s_haddr  = m1_haddr;
        s_htrans = m1_htrans;
        s_hwrite = m1_hwrite;
        s_hsize  = m1_hsize;
        s_hburst = m1_hburst;
      end else begin
        s_haddr  = m0_haddr;
        s_htrans = m0_htrans;
        s_hwrite = m0_hwrite;
        s_hsize  = m0_hsize;
        s_hburst = m0_hburst;
      end
    end
    if (nrst && r_owner == OWN_M0) s_hwdata = m0_hwdata;
    if (nrst && r_owner == OWN_M1) s_hwdata = m1_hwdata;
  end

  // Manager-side responses; held data takes precedence over the live bus.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    m0_hrdata = '0;
    m1_hrdata = '0;
    m0_hresp  = 1'b0;
    m1_hresp  = 1'b0;
    if (nrst) begin
      m0_hready = w_rdy0;
      m1_hready = w_rdy1;
      m0_hrdata = r_hold_valid[0] ? r_hold_rdata0 : s_hrdata;
      m0_hresp  = r_hold_valid[0] ? r_hold_resp0  : s_hresp;
      m1_hrdata = r_hold_valid[1] ? r_hold_rdata1 : s_hrdata;
      m1_hresp  = r_hold_valid[1] ? r_hold_resp1  : s_hresp;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_owner       <= OWN_NONE;
      r_last_grant  <= 1'b1;
      r_hold_valid  <= 2'b00;
      r_hold_rdata0 <= '0;
      r_hold_rdata1 <= '0;
      r_hold_resp0  <= 1'b0;
      r_hold_resp1  <= 1'b0;
    end else begin
      if (s_hready) begin
        if (!w_gnt_vld)  r_owner <= OWN_NONE;
        else if (w_gnt)  r_owner <= OWN_M1;
        else             r_owner <= OWN_M0;
        if (w_gnt_vld) r_last_grant <= w_gnt;
      end
      if (w_cap0) begin
        r_hold_valid[0] <= 1'b1;
        r_hold_rdata0   <= s_hrdata;
        r_hold_resp0    <= s_hresp;
      end else if (w_rdy0) begin
        r_hold_valid[0] <= 1'b0;
      end
      if (w_cap1) begin
        r_hold_valid[1] <= 1'b1;
        r_hold_rdata1   <= s_hrdata;
        r_hold_resp1    <= s_hresp;
      end else if (w_rdy1) begin
        r_hold_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  typedef enum int {K_HADDR, K_HTRANS, K_HWRITE, K_HBURST, K_HWDATA,
                    K_M0RDY, K_M1RDY, K_M0RD, K_M1RD, K_M0RESP, K_M1RESP} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [1:0]  s_htrans;
  logic        s_hwrite, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  ahb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
    .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
    .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input kind_e k);
    case (k)
      K_HADDR:  return s_haddr;
      K_HTRANS: return 32'(s_htrans);
      K_HWRITE: return 32'(s_hwrite);
      K_HBURST: return 32'(s_hburst);
      K_HWDATA: return s_hwdata;
      K_M0RDY:  return 32'(m0_hready);
      K_M1RDY:  return 32'(m1_hready);
      K_M0RD:   return m0_hrdata;
      K_M1RD:   return m1_hrdata;
      K_M0RESP: return 32'(m0_hresp);
      default:  return 32'(m1_hresp);
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_errors++;
        $display("FAIL stale_%s cyc=%0d expectation for cyc %0d never compared", e.kind.name(), cyc, e.cyc);
      end else if (actual(e.kind) !== e.val) begin
        n_errors++;
        $display("FAIL %s cyc=%0d actual=%h expected=%h", e.kind.name(), cyc, actual(e.kind), e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input kind_e k, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drv0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hburst = b; m0_hsize = 3'b010;
  endtask

  task automatic drv1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hburst = b; m1_hsize = 3'b010;
  endtask

  initial begin
    nrst = 1'b0; s_hready = 1'b1; s_hrdata = '0; s_hresp = 1'b0;
    m0_hwdata = '0; m1_hwdata = '0;
    drv0(IDLE, 0, 0, 0); drv1(IDLE, 0, 0, 0);

    // Reset with a request present: bus idle, managers ready, zero data.
    step(); drv0(NSEQ, 32'h100, 0, 0); s_hrdata = 32'h1234; s_hresp = 1'b1;
    chk(K_HTRANS, 0); chk(K_HADDR, 0); chk(K_M0RDY, 1); chk(K_M1RDY, 1);
    chk(K_M0RD, 0); chk(K_M0RESP, 0);
    step(); nrst = 1'b1; drv0(IDLE, 0, 0, 0); s_hrdata = '0; s_hresp = 1'b0;
    chk(K_HTRANS, 0); chk(K_HWDATA, 0);

    // Uncontended M0 read.
    step(); drv0(NSEQ, 32'h100, 0, 0);
    chk(K_HADDR, 32'h100); chk(K_HTRANS, 2); chk(K_M0RDY, 1); chk(K_M1RDY, 1);
    step(); drv0(IDLE, 0, 0, 0); s_hrdata = 32'hDEADBEEF;
    chk(K_M0RDY, 1); chk(K_M0RD, 32'hDEADBEEF); chk(K_M1RDY, 1); chk(K_HTRANS, 0);
    step(); nrst = 1'b0; s_hrdata = '0;

    // Contention right after reset: M0 first, then alternation with hold buffers.
    step(); nrst = 1'b1; drv0(NSEQ, 32'h10, 0, 0); drv1(NSEQ, 32'h20, 0, 0);
    chk(K_HADDR, 32'h10); chk(K_M0RDY, 1); chk(K_M1RDY, 0);
    step(); drv0(NSEQ, 32'h14, 0, 0); s_hrdata = 32'h11111111;
    chk(K_HADDR, 32'h20); chk(K_M0RDY, 0); chk(K_M1RDY, 1);
    step(); drv1(NSEQ, 32'h24, 0, 0); s_hrdata = 32'hA5A5A5A5;
    chk(K_HADDR, 32'h14); chk(K_M0RDY, 1); chk(K_M0RD, 32'h11111111);
    chk(K_M1RDY, 0); chk(K_M1RD, 32'hA5A5A5A5);
    step(); drv0(IDLE, 0, 0, 0); s_hrdata = 32'h33333333;
    chk(K_HADDR, 32'h24); chk(K_M1RDY, 1); chk(K_M1RD, 32'hA5A5A5A5);
    chk(K_M0RDY, 1); chk(K_M0RD, 32'h33333333);
    step(); drv1(IDLE, 0, 0, 0); s_hrdata = 32'h44444444;
    chk(K_M1RD, 32'h44444444); chk(K_HTRANS, 0);

    // M1 INCR4 burst locks out M0 until the fifth address phase.
    step(); drv1(NSEQ, 32'h40, 0, 3'b011);
    chk(K_HADDR, 32'h40); chk(K_HBURST, 3);
    step(); drv1(SEQ, 32'h44, 0, 3'b011); drv0(NSEQ, 32'h300, 0, 0);
    chk(K_HADDR, 32'h44); chk(K_M0RDY, 0); chk(K_M1RDY, 1);
    step(); drv1(SEQ, 32'h48, 0, 3'b011);
    chk(K_HADDR, 32'h48); chk(K_M0RDY, 0);
    step(); drv1(SEQ, 32'h4C, 0, 3'b011);
    chk(K_HADDR, 32'h4C); chk(K_M0RDY, 0); chk(K_HTRANS, 3);
    step(); drv1(IDLE, 0, 0, 0);
    chk(K_HADDR, 32'h300); chk(K_M0RDY, 1);
    step(); drv0(IDLE, 0, 0, 0);
    chk(K_HTRANS, 0);

    // M0 write with two wait states; M1 address held on the bus meanwhile.
    step(); drv0(NSEQ, 32'h200, 1, 0);
    chk(K_HADDR, 32'h200); chk(K_HWRITE, 1);
    step(); drv0(IDLE, 0, 0, 0); m0_hwdata = 32'h55; drv1(NSEQ, 32'h500, 0, 0); s_hready = 1'b0;
    chk(K_HWDATA, 32'h55); chk(K_M0RDY, 0); chk(K_M1RDY, 0); chk(K_HADDR, 32'h500);
    step();
    chk(K_HWDATA, 32'h55); chk(K_M0RDY, 0); chk(K_HADDR, 32'h500);
    step(); s_hready = 1'b1;
    chk(K_HWDATA, 32'h55); chk(K_M0RDY, 1); chk(K_M1RDY, 1); chk(K_HADDR, 32'h500);
    step(); drv1(IDLE, 0, 0, 0); m1_hwdata = 32'h77; s_hresp = 1'b1; s_hrdata = 32'h5A5A5A5A;
    chk(K_HWDATA, 32'h77); chk(K_M1RESP, 1); chk(K_M1RD, 32'h5A5A5A5A);
    step(); s_hresp = 1'b0;
    chk(K_HWDATA, 0); chk(K_HTRANS, 0);

    // Reset while M1 holds buffered data and M0 owns the data phase.
    step(); drv1(NSEQ, 32'h600, 0, 0);
    chk(K_HADDR, 32'h600);
    step(); drv0(NSEQ, 32'h700, 0, 0); drv1(NSEQ, 32'h604, 0, 0); s_hrdata = 32'hBBBBBBBB;
    chk(K_HADDR, 32'h700); chk(K_M1RDY, 0); chk(K_M0RDY, 1);
    step(); nrst = 1'b0; s_hrdata = 32'hCCCCCCCC;
    chk(K_HTRANS, 0); chk(K_M0RDY, 1); chk(K_M1RDY, 1); chk(K_M1RD, 0); chk(K_HWDATA, 0);
    step(); nrst = 1'b1; drv0(IDLE, 0, 0, 0); drv1(IDLE, 0, 0, 0);
    chk(K_HTRANS, 0); chk(K_M1RD, 32'hCCCCCCCC); chk(K_HWDATA, 0);
    chk(K_M0RDY, 1); chk(K_M1RDY, 1);
    step(); drv0(NSEQ, 32'h800, 0, 0); drv1(NSEQ, 32'h900, 0, 0);
    chk(K_HADDR, 32'h800); chk(K_M1RDY, 0);
    step(); drv0(IDLE, 0, 0, 0); drv1(IDLE, 0, 0, 0);

    step(); step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
